// File: rtl/axi_vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_vga_pkg
// Brief    : Shared types and phase-sequencing helpers for the VGA timing generator.
// Revision : 1.0
// ============================================================================
package axi_vga_pkg;

    localparam int CNT_WIDTH = 12;

    typedef enum logic [1:0] {
        PH_VISIBLE = 2'd0,
        PH_FRONT   = 2'd1,
        PH_SYNC    = 2'd2,
        PH_BACK    = 2'd3
    } phase_e;

    typedef struct packed {
        logic [CNT_WIDTH-1:0] visible;
        logic [CNT_WIDTH-1:0] front;
        logic [CNT_WIDTH-1:0] sync;
        logic [CNT_WIDTH-1:0] back;
    } axis_cfg_t;

    typedef struct packed {
        axis_cfg_t h;
        axis_cfg_t v;
        logic      hsync_pol;
        logic      vsync_pol;
    } cfg_t;

    // Phase that follows `cur`, skipping any zero-length blanking phases.
    function automatic phase_e next_phase(input phase_e cur, input axis_cfg_t cfg);
        phase_e nxt;
        nxt = PH_VISIBLE;
        case (cur)
            PH_VISIBLE: nxt = (cfg.front != '0) ? PH_FRONT :
                              (cfg.sync  != '0) ? PH_SYNC  :
                              (cfg.back  != '0) ? PH_BACK  : PH_VISIBLE;
            PH_FRONT:   nxt = (cfg.sync  != '0) ? PH_SYNC  :
                              (cfg.back  != '0) ? PH_BACK  : PH_VISIBLE;
            PH_SYNC:    nxt = (cfg.back  != '0) ? PH_BACK  : PH_VISIBLE;
            default:    nxt = PH_VISIBLE;
        endcase
        return nxt;
    endfunction

    // Terminal count of a phase; a zero length is treated as one cycle.
    function automatic logic [CNT_WIDTH-1:0] phase_last(input phase_e ph, input axis_cfg_t cfg);
        logic [CNT_WIDTH-1:0] len;
        case (ph)
            PH_VISIBLE: len = cfg.visible;
            PH_FRONT:   len = cfg.front;
            PH_SYNC:    len = cfg.sync;
            default:    len = cfg.back;
        endcase
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : axi_vga_axis_counter
// Brief    : One display axis: VISIBLE->FRONT->SYNC->BACK phase FSM with phase counter.
// Revision : 1.0
// ============================================================================
module axi_vga_axis_counter
    import axi_vga_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      i_clear,
    input  logic      i_step,
    input  axis_cfg_t i_cfg,
    output phase_e    o_phase,
    output logic      o_wrap
);

    phase_e               r_phase;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_last;
    phase_e               w_next;

    assign w_last  = (r_count == phase_last(r_phase, i_cfg));
    assign w_next  = next_phase(r_phase, i_cfg);
    // Wrap marks the final cycle of the axis period, however many phases were skipped.
    assign o_wrap  = i_step & w_last & (w_next == PH_VISIBLE);
    assign o_phase = r_phase;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_phase <= PH_VISIBLE;
            r_count <= '0;
        end else if (i_clear) begin
            r_phase <= PH_VISIBLE;
            r_count <= '0;
        end else if (i_step) begin
            if (w_last) begin
                r_phase <= w_next;
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : axi_vga_timing_gen
// Brief    : VGA timing generator pulling RGB pixels from a valid/ready stream.
//            Optional colour-bar source under AXI_VGA_TEST_PATTERN_EN.
// Revision : 1.0
// ============================================================================
module axi_vga_timing_gen
    import axi_vga_pkg::*;
#(
    parameter int RED_WIDTH   = 5,
    parameter int GREEN_WIDTH = 6,
    parameter int BLUE_WIDTH  = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  cfg_t                   timing_i,
    input  logic [RED_WIDTH-1:0]   red_i,
    input  logic [GREEN_WIDTH-1:0] green_i,
    input  logic [BLUE_WIDTH-1:0]  blue_i,
    input  logic                   valid_i,
`ifdef AXI_VGA_TEST_PATTERN_EN
    input  logic                   test_pattern_i,
`endif
    output logic                   ready_o,
    output logic [RED_WIDTH-1:0]   red_o,
    output logic [GREEN_WIDTH-1:0] green_o,
    output logic [BLUE_WIDTH-1:0]  blue_o,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   de_o,
    output logic                   underflow_o
);

    localparam int PIX_WIDTH = RED_WIDTH + GREEN_WIDTH + BLUE_WIDTH;

    cfg_t                 r_cfg;
    phase_e               w_h_phase;
    phase_e               w_v_phase;
    logic                 w_h_wrap;
    logic                 w_v_wrap;
    logic                 w_visible;
    logic                 w_pattern;
    logic [PIX_WIDTH-1:0] w_pat_rgb;

    axi_vga_axis_counter u_h_axis (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_clear (~enable_i),
        .i_step  (enable_i),
        .i_cfg   (r_cfg.h),
        .o_phase (w_h_phase),
        .o_wrap  (w_h_wrap)
    );

    axi_vga_axis_counter u_v_axis (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_clear (~enable_i),
        .i_step  (enable_i & w_h_wrap),
        .i_cfg   (r_cfg.v),
        .o_phase (w_v_phase),
        .o_wrap  (w_v_wrap)
    );

`ifdef AXI_VGA_TEST_PATTERN_EN
    logic [CNT_WIDTH-1:0] r_hpix;
    logic [CNT_WIDTH-1:0] w_hvis;
    logic [CNT_WIDTH+2:0] w_bar_full;
    logic [2:0]           w_bar;

    assign w_pattern  = test_pattern_i;
    assign w_hvis     = (r_cfg.h.visible == '0) ? CNT_WIDTH'(1) : r_cfg.h.visible;
    assign w_bar_full = {r_hpix, 3'b000} / {3'b000, w_hvis};
    assign w_bar      = w_bar_full[2:0];
    assign w_pat_rgb  = {{RED_WIDTH{w_bar[2]}}, {GREEN_WIDTH{w_bar[1]}}, {BLUE_WIDTH{w_bar[0]}}};

    // Mirrors the H visible-phase count so the bar index needs no extra counter port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hpix <= '0;
        end else if (enable_i && (w_h_phase == PH_VISIBLE) && (r_hpix != w_hvis - 1'b1)) begin
            r_hpix <= r_hpix + 1'b1;
        end else begin
            r_hpix <= '0;
        end
    end
`else
    assign w_pattern = 1'b0;
    assign w_pat_rgb = '0;
`endif

    assign w_visible = (w_h_phase == PH_VISIBLE) && (w_v_phase == PH_VISIBLE);
    assign ready_o   = enable_i & w_visible & ~w_pattern;

    // Shadow timing only moves while idle or on the final cycle of a frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cfg <= '0;
        end else if (!enable_i || w_v_wrap) begin
            r_cfg <= timing_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            {red_o, green_o, blue_o} <= '0;
            de_o        <= 1'b0;
            underflow_o <= 1'b0;
            hsync_o     <= 1'b0;
            vsync_o     <= 1'b0;
        end else if (!enable_i) begin
            {red_o, green_o, blue_o} <= '0;
            de_o        <= 1'b0;
            underflow_o <= 1'b0;
            hsync_o     <= ~timing_i.hsync_pol;
            vsync_o     <= ~timing_i.vsync_pol;
        end else begin
            hsync_o <= (w_h_phase == PH_SYNC) ? r_cfg.hsync_pol : ~r_cfg.hsync_pol;
            vsync_o <= (w_v_phase == PH_SYNC) ? r_cfg.vsync_pol : ~r_cfg.vsync_pol;
            de_o    <= w_visible;
            if (w_visible && w_pattern) begin
                {red_o, green_o, blue_o} <= w_pat_rgb;
            end else if (w_visible && valid_i) begin
                {red_o, green_o, blue_o} <= {red_i, green_i, blue_i};
            end else begin
                {red_o, green_o, blue_o} <= '0;
                if (w_visible) begin
                    underflow_o <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_vga_timing_gen
// Brief    : Randomized bench; expected outputs come from a frame-position model.
// Revision : 1.0
// ============================================================================
module tb_axi_vga_timing_gen;
    import axi_vga_pkg::*;

    localparam int RW = 5;
    localparam int GW = 6;
    localparam int BW = 5;

    logic          clk_i    = 1'b0;
    logic          rst_ni   = 1'b0;
    logic          enable_i = 1'b0;
    logic          valid_i  = 1'b0;
    cfg_t          timing_i;
    logic [RW-1:0] red_i    = '0;
    logic [GW-1:0] green_i  = '0;
    logic [BW-1:0] blue_i   = '0;
    logic          ready_o;
    logic [RW-1:0] red_o;
    logic [GW-1:0] green_o;
    logic [BW-1:0] blue_o;
    logic          hsync_o;
    logic          vsync_o;
    logic          de_o;
    logic          underflow_o;

    int total = 0;
    int bad   = 0;

    // Model state: cycle position inside the current frame and the timing in force.
    cfg_t        m_cfg;
    int          m_t     = 0;
    logic        m_under = 1'b0;
    logic        m_ready = 1'b0;
    logic [19:0] m_exp   = '0;
    logic        obs_ready = 1'b0;
    logic [20:0] obs_vec;
    logic [20:0] exp_vec;

    // Per-run history of observed outputs, indexed by enabled-cycle number.
    logic        h_de [0:255];
    logic        h_hs [0:255];
    logic        h_vs [0:255];

    assign obs_vec = {red_o, green_o, blue_o, de_o, hsync_o, vsync_o, underflow_o, obs_ready};
    assign exp_vec = {m_exp, m_ready};

    always #5 clk_i = ~clk_i;

    axi_vga_timing_gen #(
        .RED_WIDTH   (RW),
        .GREEN_WIDTH (GW),
        .BLUE_WIDTH  (BW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enable_i    (enable_i),
        .timing_i    (timing_i),
        .red_i       (red_i),
        .green_i     (green_i),
        .blue_i      (blue_i),
        .valid_i     (valid_i),
`ifdef AXI_VGA_TEST_PATTERN_EN
        .test_pattern_i (1'b0),
`endif
        .ready_o     (ready_o),
        .red_o       (red_o),
        .green_o     (green_o),
        .blue_o      (blue_o),
        .hsync_o     (hsync_o),
        .vsync_o     (vsync_o),
        .de_o        (de_o),
        .underflow_o (underflow_o)
    );

    function automatic int vis_len(input logic [CNT_WIDTH-1:0] v);
        return (v == '0) ? 1 : int'(v);
    endfunction

    function automatic int axis_total(input axis_cfg_t a);
        return vis_len(a.visible) + int'(a.front) + int'(a.sync) + int'(a.back);
    endfunction

    function automatic cfg_t make_cfg(input int hv, input int hf, input int hs, input int hb,
                                      input int vv, input int vf, input int vs, input int vb,
                                      input logic hp, input logic vp);
        cfg_t c;
        c.h.visible = 12'(hv); c.h.front = 12'(hf); c.h.sync = 12'(hs); c.h.back = 12'(hb);
        c.v.visible = 12'(vv); c.v.front = 12'(vf); c.v.sync = 12'(vs); c.v.back = 12'(vb);
        c.hsync_pol = hp;
        c.vsync_pol = vp;
        return c;
    endfunction

    // True if the next enabled cycle lands in the visible area.
    function automatic logic model_visible();
        int ht;
        ht = axis_total(m_cfg.h);
        return ((m_t % ht) < vis_len(m_cfg.h.visible)) && ((m_t / ht) < vis_len(m_cfg.v.visible));
    endfunction

    // One clock: drive inputs, advance the model, leave outputs settled for checking.
    task automatic step(input logic en, input logic vld);
        int   ht, vt, x, y, hsb, vsb;
        logic vis, hs, vs;
        @(negedge clk_i);
        enable_i = en;
        valid_i  = vld;
        red_i    = RW'($urandom);
        green_i  = GW'($urandom);
        blue_i   = BW'($urandom);
        #1;
        obs_ready = ready_o;
        if (!en) begin
            m_t     = 0;
            m_cfg   = timing_i;
            m_under = 1'b0;
            m_ready = 1'b0;
            m_exp   = {16'b0, 1'b0, ~timing_i.hsync_pol, ~timing_i.vsync_pol, 1'b0};
        end else begin
            ht  = axis_total(m_cfg.h);
            vt  = axis_total(m_cfg.v);
            x   = m_t % ht;
            y   = m_t / ht;
            vis = (x < vis_len(m_cfg.h.visible)) && (y < vis_len(m_cfg.v.visible));
            hsb = vis_len(m_cfg.h.visible) + int'(m_cfg.h.front);
            vsb = vis_len(m_cfg.v.visible) + int'(m_cfg.v.front);
            hs  = (x >= hsb) && (x < hsb + int'(m_cfg.h.sync));
            vs  = (y >= vsb) && (y < vsb + int'(m_cfg.v.sync));
            m_ready = vis;
            if (vis && !vld) m_under = 1'b1;
            m_exp = {(vis && vld) ? {red_i, green_i, blue_i} : 16'b0, vis,
                     hs ? m_cfg.hsync_pol : ~m_cfg.hsync_pol,
                     vs ? m_cfg.vsync_pol : ~m_cfg.vsync_pol, m_under};
            m_t++;
            if (m_t == ht * vt) begin
                m_t   = 0;
                m_cfg = timing_i;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        timing_i = make_cfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        rst_ni   = 1'b0;
        enable_i = 1'b0;
        #23;
        total++;
        if ({red_o, green_o, blue_o, de_o, hsync_o, vsync_o, underflow_o, ready_o} !== 21'b0) begin
            bad++;
            $display("FAIL reset_asserted got=%h exp=0", {red_o, green_o, blue_o, de_o, hsync_o, vsync_o, underflow_o, ready_o});
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1);
            total++;
            if (obs_vec !== exp_vec || {hsync_o, vsync_o, de_o} !== 3'b000) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
        end
    endtask

    // Runs `n` enabled cycles with full model checks; `drop_at` picks a visible pixel to starve.
    task automatic run_checked(input string name, input int n, input int drop_at);
        int nvis;
        logic vld;
        nvis = 0;
        for (int i = 0; i < n; i++) begin
            vld = 1'b1;
            if (model_visible()) begin
                if (nvis == drop_at) vld = 1'b0;
                nvis++;
            end
            step(1'b1, vld);
            if (i < 256) begin
                h_de[i] = de_o;
                h_hs[i] = hsync_o;
                h_vs[i] = vsync_o;
            end
            total++;
            if (obs_vec !== exp_vec) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", name, i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_basic_frame();
        int de_cnt, hs_ok, hs_cnt, vs_rise0, vs_rise1;
        timing_i = make_cfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        step(1'b0, 1'b1);
        run_checked("basic", 96, -1);
        de_cnt = 0; hs_ok = 0; hs_cnt = 0; vs_rise0 = -1; vs_rise1 = -1;
        for (int i = 48; i < 96; i++) begin
            if (h_de[i]) de_cnt++;
            if (h_hs[i]) hs_cnt++;
            if (h_hs[i] && ((i % 8) == 5 || (i % 8) == 6)) hs_ok++;
        end
        for (int i = 1; i < 96; i++) begin
            if (h_vs[i] && !h_vs[i-1]) begin
                if (vs_rise0 < 0) vs_rise0 = i;
                else if (vs_rise1 < 0) vs_rise1 = i;
            end
        end
        total++;
        if (de_cnt !== 12) begin
            bad++;
            $display("FAIL basic_de_per_frame got=%0d exp=12", de_cnt);
        end
        total++;
        if (hs_cnt !== 12 || hs_ok !== 12) begin
            bad++;
            $display("FAIL basic_hsync_slots got=%0d/%0d exp=12/12", hs_cnt, hs_ok);
        end
        total++;
        if (vs_rise1 - vs_rise0 !== 48) begin
            bad++;
            $display("FAIL basic_frame_period got=%0d exp=48", vs_rise1 - vs_rise0);
        end
    endtask

    task automatic test_underflow();
        timing_i = make_cfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        step(1'b0, 1'b1);
        run_checked("underflow", 60, 2);
        total++;
        if (underflow_o !== 1'b1) begin
            bad++;
            $display("FAIL underflow_sticky got=%b exp=1", underflow_o);
        end
        step(1'b0, 1'b1);
        total++;
        if (underflow_o !== 1'b0 || de_o !== 1'b0) begin
            bad++;
            $display("FAIL underflow_clear got=%b%b exp=00", underflow_o, de_o);
        end
    endtask

    task automatic test_hvis_change();
        int de_cnt;
        timing_i = make_cfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        step(1'b0, 1'b1);
        run_checked("hvis_a", 10, -1);
        timing_i.h.visible = 12'd6;
        run_checked("hvis_b", 98, -1);
        // Continuous history: first 10 cycles were overwritten, so re-derive from offsets.
        de_cnt = 0;
        for (int i = 38; i < 48; i++) if (h_de[i]) de_cnt++;
        total++;
        if (de_cnt !== 6 || h_de[48] !== 1'b1 || h_de[37] !== 1'b0) begin
            bad++;
            $display("FAIL hvis_next_frame got=%0d/%b exp=6/1", de_cnt, h_de[48]);
        end
    endtask

    task automatic test_front_zero();
        int hits, edges;
        timing_i = make_cfg(4, 0, 2, 2, 3, 1, 1, 1, 1'b1, 1'b0);
        step(1'b0, 1'b1);
        run_checked("front0", 48, -1);
        hits = 0; edges = 0;
        for (int i = 1; i < 48; i++) begin
            if (h_de[i-1] && !h_de[i]) begin
                edges++;
                if (h_hs[i]) hits++;
            end
        end
        total++;
        if (edges !== 3 || hits !== 3) begin
            bad++;
            $display("FAIL front0_hsync_after_de got=%0d/%0d exp=3/3", hits, edges);
        end
    endtask

    task automatic test_enable_drop();
        timing_i = make_cfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        step(1'b0, 1'b1);
        run_checked("drop_a", 11, 1);
        step(1'b0, 1'b1);
        total++;
        if (obs_vec !== exp_vec || underflow_o !== 1'b0) begin
            bad++;
            $display("FAIL drop_idle got=%h exp=%h", obs_vec, exp_vec);
        end
        run_checked("drop_b", 20, -1);
        total++;
        if (h_de[0] !== 1'b1 || h_de[4] !== 1'b0 || underflow_o !== 1'b0) begin
            bad++;
            $display("FAIL drop_restart got=%b%b%b exp=100", h_de[0], h_de[4], underflow_o);
        end
    endtask

    task automatic test_random();
        logic vld;
        for (int r = 0; r < 6; r++) begin
            timing_i = make_cfg($urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 2),
                                $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2),
                                $urandom_range(0, 2), $urandom_range(0, 2),
                                1'($urandom), 1'($urandom));
            step(1'b0, 1'b1);
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 99) == 0) timing_i.h.visible = 12'($urandom_range(1, 6));
                if ($urandom_range(0, 99) == 0) timing_i.v.sync = 12'($urandom_range(0, 2));
                vld = ($urandom_range(0, 9) != 0);
                step(($urandom_range(0, 79) != 0), vld);
                total++;
                if (obs_vec !== exp_vec) begin
                    bad++;
                    $display("FAIL random run=%0d cyc=%0d got=%h exp=%h", r, i, obs_vec, exp_vec);
                end
            end
        end
    endtask

    initial begin
        timing_i = '0;
        m_cfg    = '0;
        test_reset();
        test_basic_frame();
        test_underflow();
        test_hvis_change();
        test_front_zero();
        test_enable_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
